// File: rtl/systolic_writeback.sv
// rtl/systolic_writeback.sv - result-vector FIFO and serialiser onto one memory write port (optional WRITEBACK_RELU_EN)
module systolic_writeback #(
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    ARRAY_SIZE_K_MAX = 8,
    parameter int                    FIFO_DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE      = 32'h00003000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [7:0]                             k_cols,
    input  logic [ADDR_WIDTH-1:0]                  m_rows,
    input  logic                                   y_valid,
    input  logic [ADDR_WIDTH-1:0]                  y_row,
    input  logic [DATA_WIDTH*ARRAY_SIZE_K_MAX-1:0] y_data,
    output logic                                   y_ready,
    output logic                                   mem_wr_en,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [DATA_WIDTH-1:0]                  mem_data,
    input  logic                                   mem_gnt,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int VEC_W = DATA_WIDTH * ARRAY_SIZE_K_MAX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_LAST
    } state_t;

    state_t                  state, state_n;
    logic [7:0]              col, col_n;
    logic [ADDR_WIDTH-1:0]   rows_written, rows_n;
    logic [ADDR_WIDTH-1:0]   row_q;
    logic [VEC_W-1:0]        vec_q;
    logic                    load_hold;
    logic                    wr_en_n;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic [DATA_WIDTH-1:0]   data_n;

    logic [ADDR_WIDTH-1:0]   fifo_row [FIFO_DEPTH];
    logic [VEC_W-1:0]        fifo_vec [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    push, fifo_pop;
    logic [ADDR_WIDTH-1:0]   head_row;
    logic [VEC_W-1:0]        head_vec;

    // Selects element idx of a vector; out-of-range indices read as zero.
    function automatic logic [DATA_WIDTH-1:0] pick(input logic [VEC_W-1:0] v, input logic [7:0] idx);
        logic [DATA_WIDTH-1:0] e;
        e = '0;
        for (int j = 0; j < ARRAY_SIZE_K_MAX; j++) begin
            if (idx == 8'(j)) begin
                e = v[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`ifdef WRITEBACK_RELU_EN
        if (e[DATA_WIDTH-1]) begin
            e = '0;
        end
`endif
        return e;
    endfunction

    // Row-major word address; wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] row,
                                                      input logic [7:0] k, input logic [7:0] c);
        return OUTPUT_BASE + row * ADDR_WIDTH'(k) + ADDR_WIDTH'(c);
    endfunction

    assign y_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign push     = y_valid && y_ready;
    assign fifo_pop = (state == ST_IDLE) && (count != '0);
    assign head_row = fifo_row[rd_ptr];
    assign head_vec = fifo_vec[rd_ptr];
    assign done     = (state == ST_LAST) && (m_rows != '0) && (rows_written == m_rows);
    assign busy     = (count != '0) || (state != ST_IDLE);

    // FIFO storage: no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_row[wr_ptr] <= y_row;
            fifo_vec[wr_ptr] <= y_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (y_valid && !y_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Next-state, counters and next registered write-port values.
    always_comb begin
        state_n   = state;
        col_n     = col;
        rows_n    = rows_written;
        load_hold = 1'b0;
        wr_en_n   = mem_wr_en;
        addr_n    = mem_addr;
        data_n    = mem_data;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    load_hold = 1'b1;
                    col_n     = 8'd0;
                    if (k_cols == 8'd0) begin
                        rows_n  = rows_written + 1'b1;
                        state_n = ST_LAST;
                    end else begin
                        state_n = ST_WRITE;
                        wr_en_n = 1'b1;
                        addr_n  = addr_of(head_row, k_cols, 8'd0);
                        data_n  = pick(head_vec, 8'd0);
                    end
                end
            end
            ST_WRITE: begin
                if (mem_gnt) begin
                    col_n = col + 8'd1;
                    if (col + 8'd1 >= k_cols) begin
                        rows_n  = rows_written + 1'b1;
                        state_n = ST_LAST;
                        wr_en_n = 1'b0;
                        addr_n  = '0;
                        data_n  = '0;
                    end else begin
                        addr_n = addr_of(row_q, k_cols, col + 8'd1);
                        data_n = pick(vec_q, col + 8'd1);
                    end
                end
            end
            ST_LAST: begin
                wr_en_n = 1'b0;
                addr_n  = '0;
                data_n  = '0;
                if (done) begin
                    rows_n = '0;
                end
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                wr_en_n = 1'b0;
                addr_n  = '0;
                data_n  = '0;
            end
        endcase
    end

    // State, holding registers and registered memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            col          <= 8'd0;
            rows_written <= '0;
            row_q        <= '0;
            vec_q        <= '0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
        end else begin
            state        <= state_n;
            col          <= col_n;
            rows_written <= rows_n;
            mem_wr_en    <= wr_en_n;
            mem_addr     <= addr_n;
            mem_data     <= data_n;
            if (load_hold) begin
                row_q <= head_row;
                vec_q <= head_vec;
            end
        end
    end

endmodule
